// File: rtl/input_feeder.sv
// Fetches N rows from input memory into a row buffer, then feeds them to a
// 4-lane systolic array with a one-cycle skew per lane and MAC_READY stalls.
module input_feeder #(
   parameter int unsigned ELEM_W = 16
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  START_CALC,
   input  logic [3:0]            ISRC,
   input  logic [2:0]            NROWS,
   output logic                  IMEM_Read,
   output logic [3:0]            IMEM_Addr,
   input  logic [4*ELEM_W-1:0]   IMEM_Data,
   output logic [4*ELEM_W-1:0]   MAC_IDATA,
   output logic [3:0]            MAC_IVALID,
   input  logic                  MAC_READY,
   output logic                  BUSY,
   output logic                  Feed_Done
);

   localparam int unsigned LANES = 4;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned ROW_W = LANES * ELEM_W;

   typedef enum logic [1:0] {IDLE, FETCH, FEED} state_t;

   state_t           state;
   logic [3:0]       n_rows;
   logic [3:0]       base;
   logic [3:0]       rd_idx;
   logic [2:0]       cap_idx;
   logic             cap_en;
   logic [3:0]       feed_c;
   logic [ROW_W-1:0] row_buf  [DEPTH];
   logic [ROW_W-1:0] buf_view [DEPTH];
   logic [3:0]       nxt_c;
   logic [3:0]       nxt_valid;
   logic [ROW_W-1:0] nxt_data;
   int               diff;

   // Row buffer has no reset; its contents only matter after a fetch
   always_ff @(posedge CLK) begin
      if (cap_en) row_buf[cap_idx] <= IMEM_Data;
   end

   // Skewed lane data for the next feed cycle; the bypass covers the case where
   // the row needed for c=0 is being captured on the FETCH->FEED edge
   always_comb begin
      buf_view = row_buf;
      if (cap_en) buf_view[cap_idx] = IMEM_Data;
      nxt_c     = (state == FEED) ? feed_c + 4'd1 : 4'd0;
      nxt_valid = '0;
      nxt_data  = '0;
      diff      = 0;
      for (int k = 0; k < int'(LANES); k++) begin
         diff = int'(nxt_c) - k;
         if (diff >= 0 && diff < int'(n_rows)) begin
            nxt_valid[k] = 1'b1;
            nxt_data[(LANES-1-k)*ELEM_W +: ELEM_W] =
               buf_view[3'(diff)][(LANES-1-k)*ELEM_W +: ELEM_W];
         end
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state      <= IDLE;
         n_rows     <= '0;
         base       <= '0;
         rd_idx     <= '0;
         cap_idx    <= '0;
         cap_en     <= 1'b0;
         feed_c     <= '0;
         IMEM_Read  <= 1'b0;
         IMEM_Addr  <= '0;
         MAC_IDATA  <= '0;
         MAC_IVALID <= '0;
         BUSY       <= 1'b0;
         Feed_Done  <= 1'b0;
      end else begin
         Feed_Done <= 1'b0;
         cap_en    <= IMEM_Read;
         case (state)
            IDLE: begin
               // A start coinciding with the Feed_Done pulse is dropped
               if (START_CALC && !Feed_Done) begin
                  state     <= FETCH;
                  n_rows    <= (NROWS == 3'd0) ? 4'd8 : {1'b0, NROWS};
                  base      <= ISRC;
                  IMEM_Read <= 1'b1;
                  IMEM_Addr <= ISRC;
                  rd_idx    <= 4'd1;
                  cap_idx   <= '0;
                  feed_c    <= '0;
                  BUSY      <= 1'b1;
               end
            end
            FETCH: begin
               if (rd_idx < n_rows) begin
                  IMEM_Read <= 1'b1;
                  IMEM_Addr <= base + rd_idx;
                  rd_idx    <= rd_idx + 4'd1;
               end else begin
                  IMEM_Read <= 1'b0;
               end
               if (cap_en) begin
                  cap_idx <= cap_idx + 3'd1;
                  if (4'(cap_idx) == n_rows - 4'd1) begin
                     state      <= FEED;
                     feed_c     <= '0;
                     MAC_IVALID <= nxt_valid;
                     MAC_IDATA  <= nxt_data;
                  end
               end
            end
            FEED: begin
               if (MAC_READY) begin
                  if (feed_c == n_rows + 4'd2) begin
                     state      <= IDLE;
                     feed_c     <= '0;
                     rd_idx     <= '0;
                     MAC_IVALID <= '0;
                     MAC_IDATA  <= '0;
                     BUSY       <= 1'b0;
                     Feed_Done  <= 1'b1;
                  end else begin
                     feed_c     <= nxt_c;
                     MAC_IVALID <= nxt_valid;
                     MAC_IDATA  <= nxt_data;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_input_feeder.sv
// Directed bench for input_feeder: fetch/feed timing, skew, stalls,
// ignored starts and mid-operation reset.
module tb_input_feeder;

   localparam int unsigned ELEM_W = 16;
   localparam int unsigned ROW_W  = 4 * ELEM_W;

   logic             CLK = 1'b0;
   logic             RSTN;
   logic             START_CALC;
   logic [3:0]       ISRC;
   logic [2:0]       NROWS;
   logic             IMEM_Read;
   logic [3:0]       IMEM_Addr;
   logic [ROW_W-1:0] IMEM_Data;
   logic [ROW_W-1:0] MAC_IDATA;
   logic [3:0]       MAC_IVALID;
   logic             MAC_READY;
   logic             BUSY;
   logic             Feed_Done;

   logic [ROW_W-1:0] mem [16];
   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   input_feeder #(.ELEM_W(ELEM_W)) dut (
      .CLK(CLK), .RSTN(RSTN), .START_CALC(START_CALC), .ISRC(ISRC), .NROWS(NROWS),
      .IMEM_Read(IMEM_Read), .IMEM_Addr(IMEM_Addr), .IMEM_Data(IMEM_Data),
      .MAC_IDATA(MAC_IDATA), .MAC_IVALID(MAC_IVALID), .MAC_READY(MAC_READY),
      .BUSY(BUSY), .Feed_Done(Feed_Done)
   );

   always #5 CLK = ~CLK;

   // Memory model: data valid the cycle after the read strobe
   always @(posedge CLK) begin
      IMEM_Data <= IMEM_Read ? mem[IMEM_Addr] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (Feed_Done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic start(input logic [3:0] src, input logic [2:0] nr);
      START_CALC = 1'b1;
      ISRC       = src;
      NROWS      = nr;
   endtask

   // N=1 from address 3; caller sits in cycle 0
   task automatic run_n1(input string p);
      start(4'd3, 3'd1);
      chk({p, "_c0_busy"}, 64'(BUSY), 64'd0);
      step(); START_CALC = 1'b0;
      chk({p, "_c1_read"}, 64'(IMEM_Read), 64'd1);
      chk({p, "_c1_addr"}, 64'(IMEM_Addr), 64'd3);
      chk({p, "_c1_busy"}, 64'(BUSY), 64'd1);
      step();
      chk({p, "_c2_read"}, 64'(IMEM_Read), 64'd0);
      chk({p, "_c2_valid"}, 64'(MAC_IVALID), 64'd0);
      step();
      chk({p, "_c3_valid"}, 64'(MAC_IVALID), 64'b0001);
      chk({p, "_c3_data"}, MAC_IDATA, 64'h1111_0000_0000_0000);
      step();
      chk({p, "_c4_valid"}, 64'(MAC_IVALID), 64'b0010);
      chk({p, "_c4_data"}, MAC_IDATA, 64'h0000_2222_0000_0000);
      step();
      chk({p, "_c5_valid"}, 64'(MAC_IVALID), 64'b0100);
      chk({p, "_c5_data"}, MAC_IDATA, 64'h0000_0000_3333_0000);
      step();
      chk({p, "_c6_valid"}, 64'(MAC_IVALID), 64'b1000);
      chk({p, "_c6_data"}, MAC_IDATA, 64'h0000_0000_0000_4444);
      chk({p, "_c6_done"}, 64'(Feed_Done), 64'd0);
      step();
      chk({p, "_c7_done"}, 64'(Feed_Done), 64'd1);
      chk({p, "_c7_busy"}, 64'(BUSY), 64'd0);
      chk({p, "_c7_valid"}, 64'(MAC_IVALID), 64'd0);
      step();
      chk({p, "_c8_done"}, 64'(Feed_Done), 64'd0);
   endtask

   initial begin
      logic [3:0]       vpat [11];
      logic [ROW_W-1:0] ed;
      int               d0;
      int               d;

      RSTN = 1'b0; START_CALC = 1'b0; ISRC = '0; NROWS = '0; MAC_READY = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      step(); step();
      chk("rst_read", 64'(IMEM_Read), 64'd0);
      chk("rst_addr", 64'(IMEM_Addr), 64'd0);
      chk("rst_valid", 64'(MAC_IVALID), 64'd0);
      chk("rst_data", MAC_IDATA, 64'd0);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_done", 64'(Feed_Done), 64'd0);
      RSTN = 1'b1;
      step();

      // N=1
      mem[3] = 64'h1111_2222_3333_4444;
      run_n1("n1");

      // N=8 with address wrap
      for (int r = 0; r < 8; r++)
         mem[(14 + r) & 15] = {16'(r*16), 16'(r*16+1), 16'(r*16+2), 16'(r*16+3)};
      vpat = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111,
               4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      start(4'd14, 3'd0);
      step(); START_CALC = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("n8_rd%0d", i), 64'(IMEM_Read), 64'd1);
         chk($sformatf("n8_addr%0d", i), 64'(IMEM_Addr), 64'((13 + i) & 15));
         step();
      end
      chk("n8_c9_read", 64'(IMEM_Read), 64'd0);
      chk("n8_c9_valid", 64'(MAC_IVALID), 64'd0);
      step();
      for (int c = 0; c <= 10; c++) begin
         ed = '0;
         for (int k = 0; k < 4; k++) begin
            d = c - k;
            if (d >= 0 && d < 8) ed[(3-k)*16 +: 16] = 16'(d*16 + k);
         end
         chk($sformatf("n8_valid_c%0d", c), 64'(MAC_IVALID), 64'(vpat[c]));
         chk($sformatf("n8_data_c%0d", c), MAC_IDATA, ed);
         chk($sformatf("n8_done_c%0d", c), 64'(Feed_Done), 64'd0);
         step();
      end
      chk("n8_done", 64'(Feed_Done), 64'd1);
      step();

      // N=2 with stall at c=1; READY low during fetch must be ignored
      mem[6] = 64'h0A01_0A02_0A03_0A04;
      mem[7] = 64'h0B01_0B02_0B03_0B04;
      start(4'd6, 3'd2);
      MAC_READY = 1'b0;
      step(); START_CALC = 1'b0;
      step();
      step();
      chk("st_c3_valid", 64'(MAC_IVALID), 64'd0);
      MAC_READY = 1'b1;
      step();
      chk("st_c4_valid", 64'(MAC_IVALID), 64'b0001);
      chk("st_c4_data", MAC_IDATA, 64'h0A01_0000_0000_0000);
      step();
      MAC_READY = 1'b0;
      for (int i = 5; i <= 8; i++) begin
         if (i == 8) MAC_READY = 1'b1;
         chk($sformatf("st_c%0d_valid", i), 64'(MAC_IVALID), 64'b0011);
         chk($sformatf("st_c%0d_data", i), MAC_IDATA, 64'h0B01_0A02_0000_0000);
         step();
      end
      chk("st_c9_valid", 64'(MAC_IVALID), 64'b0110);
      chk("st_c9_data", MAC_IDATA, 64'h0000_0B02_0A03_0000);
      step();
      chk("st_c10_valid", 64'(MAC_IVALID), 64'b1100);
      chk("st_c10_data", MAC_IDATA, 64'h0000_0000_0B03_0A04);
      step();
      chk("st_c11_valid", 64'(MAC_IVALID), 64'b1000);
      chk("st_c11_data", MAC_IDATA, 64'h0000_0000_0000_0B04);
      chk("st_c11_done", 64'(Feed_Done), 64'd0);
      step();
      chk("st_c12_done", 64'(Feed_Done), 64'd1);
      step();

      // N=4, second start mid-fetch and a start on the Feed_Done cycle
      d0 = done_cnt;
      start(4'd10, 3'd4);
      step(); START_CALC = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ig_addr%0d", i), 64'(IMEM_Addr), 64'(9 + i));
         if (i == 4) start(4'd0, 3'd1);
         step();
         START_CALC = 1'b0;
      end
      chk("ig_c5_read", 64'(IMEM_Read), 64'd0);
      step();
      chk("ig_c6_valid", 64'(MAC_IVALID), 64'b0001);
      for (int i = 7; i <= 12; i++) step();
      chk("ig_c12_done", 64'(Feed_Done), 64'd0);
      step();
      chk("ig_c13_done", 64'(Feed_Done), 64'd1);
      start(4'd3, 3'd1);
      step(); START_CALC = 1'b0;
      chk("ig_c14_busy", 64'(BUSY), 64'd0);
      chk("ig_c14_read", 64'(IMEM_Read), 64'd0);
      step();
      chk("ig_c15_read", 64'(IMEM_Read), 64'd0);
      chk("ig_done_cnt", 64'(done_cnt - d0), 64'd1);

      // Reset at feed c=2 of an N=3 run
      start(4'd0, 3'd3);
      step(); START_CALC = 1'b0;
      for (int i = 2; i <= 7; i++) step();
      chk("rs_c7_valid", 64'(MAC_IVALID), 64'b0111);
      RSTN = 1'b0;
      #1;
      chk("rs_valid", 64'(MAC_IVALID), 64'd0);
      chk("rs_data", MAC_IDATA, 64'd0);
      chk("rs_busy", 64'(BUSY), 64'd0);
      chk("rs_read", 64'(IMEM_Read), 64'd0);
      chk("rs_done", 64'(Feed_Done), 64'd0);
      step(); step();
      RSTN = 1'b1;
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rs_idle%0d_busy", i), 64'(BUSY), 64'd0);
         chk($sformatf("rs_idle%0d_valid", i), 64'(MAC_IVALID), 64'd0);
         step();
      end
      chk("rs_no_done", 64'(done_cnt - d0), 64'd0);
      mem[3] = 64'h1111_2222_3333_4444;
      run_n1("rs_n1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
